// File: rtl/wei_disp_pkg.sv
// Shared types and constants for the weight-data dispatch stage.
// No logic: FSM encoding, tag field widths and the tagged-entry layout.
// Entries are {data, tag}, where the tag occupies the low TAG_W bits.
package wei_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b11
  } disp_state_e;

  localparam int PEB_IDX_W = 4;
  localparam int PE_IDX_W  = 5;
  localparam int TYPE_W    = 3;
  localparam int TAG_W     = PEB_IDX_W + PE_IDX_W + TYPE_W;

  // Tag captured alongside each weight word
  typedef struct packed {
    logic [PEB_IDX_W-1:0] peb;
    logic [PE_IDX_W-1:0]  pe;
    logic [TYPE_W-1:0]    dtype;
  } wei_tag_t;

  // Width of one buffered entry for a given SRAM word width
  function automatic int entry_w(input int port_width);
    return port_width + TAG_W;
  endfunction

endpackage

// File: rtl/wei_data_dispatch_if.sv
// PE-block side bundle of the dispatch stage: one-hot valid, per-PEB ready, head word and tags.
// No latency of its own; plain wires.
// The master drives valid/data and the slave returns ready; valid never waits on ready.
interface wei_data_dispatch_if
  import wei_disp_pkg::*;
#(
  parameter int PORT_WIDTH = 128,
  parameter int NUM_PEB    = 16
);
  logic [NUM_PEB-1:0]    GBWEI_data_val_all;
  logic [NUM_PEB-1:0]    PEGB_data_rdy_all;
  logic [PORT_WIDTH-1:0] GBWEI_data;
  logic [PE_IDX_W-1:0]   GBWEI_pe_idx;
  logic [TYPE_W-1:0]     GBWEI_data_type;

  modport master (
    output GBWEI_data_val_all, GBWEI_data, GBWEI_pe_idx, GBWEI_data_type,
    input  PEGB_data_rdy_all
  );

  modport slave (
    input  GBWEI_data_val_all, GBWEI_data, GBWEI_pe_idx, GBWEI_data_type,
    output PEGB_data_rdy_all
  );
endinterface

// File: rtl/wei_disp_fifo.sv
// Synchronous FIFO with flush, occupancy count and same-cycle push/pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module wei_disp_fifo #(
  parameter int DW    = 140,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic          w_wr;
  logic          w_rd;

  // Pointers carry one extra MSB so full and empty differ only in that bit
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[CW-1] != r_rptr[CW-1]) && (r_wptr[CW-2:0] == r_rptr[CW-2:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_head  = r_mem[r_rptr[CW-2:0]];
  assign w_rd    = i_pop && !o_empty && !i_flush;
  assign w_wr    = i_push && (!o_full || w_rd) && !i_flush;

  // Pointer update; flush drops every entry at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[CW-2:0]] <= i_dat;
  end

endmodule

// File: rtl/wei_data_dispatch.sv
// Tags weight-SRAM read words with PEB/PE/type and delivers them to the addressed PE block.
// Latency: read_en at t, buffered at end of t+1, valid at t+2; one word per cycle sustained.
// Backpressure: per-PEB ready pops the head; credit drops when buffered + in-flight reach depth.
module wei_data_dispatch
  import wei_disp_pkg::*;
#(
  parameter int PORT_WIDTH = 128,
  parameter int NUM_PEB    = 16,
  parameter int PE_NUM     = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SRAM_config_start,
  input  logic                  WeiData_read_en,
  input  logic [PEB_IDX_W-1:0]  Which_PEB_to_PE,
  input  logic [PE_IDX_W-1:0]   Which_PE_to_PE,
  input  logic [TYPE_W-1:0]     data_type,
  input  logic                  read_SRAM_done,
  input  logic [PORT_WIDTH-1:0] WeiData_rdata,
  wei_data_dispatch_if.master   pe_if,
  output logic                  Wei_credit_ok,
  output logic                  dispatch_done,
  output logic                  dispatch_err
);

  localparam int EW = entry_w(PORT_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PEB_IDX_W:0] LP_NUM_PEB = (PEB_IDX_W + 1)'(NUM_PEB);
  localparam logic [CW:0]        LP_DEPTH   = (CW + 1)'(FIFO_DEPTH);

  // Configurations the index fields or the FIFO pointers cannot represent are rejected
  if (PE_NUM > (1 << PE_IDX_W) || NUM_PEB > (1 << PEB_IDX_W) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
    $error("wei_data_dispatch: unsupported parameter set");
  end

  disp_state_e         r_state;
  disp_state_e         w_state_nxt;
  logic                r_inflight;
  wei_tag_t            r_tag;
  logic                r_err;
  logic [EW-1:0]       w_head;
  wei_tag_t            w_head_tag;
  logic                w_empty;
  logic                w_full;
  logic [CW-1:0]       w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_active;
  logic                w_bad;
  logic                w_rdy_sel;
  logic                w_ovf;
  logic [NUM_PEB-1:0]  w_onehot;

  assign w_head_tag = w_head[TAG_W-1:0];
  assign w_active   = (r_state != IDLE);
  assign w_bad      = ({1'b0, w_head_tag.peb} >= LP_NUM_PEB);
  assign w_push     = r_inflight && !SRAM_config_start;
  assign w_rdy_sel  = |(w_onehot & pe_if.PEGB_data_rdy_all);
  // A bad-index head is discarded without ever raising a valid bit
  assign w_pop      = !w_empty && w_active && (w_bad || w_rdy_sel) && !SRAM_config_start;
  assign w_ovf      = w_push && w_full && !w_pop;

  assign pe_if.GBWEI_data_val_all = (!w_empty && w_active && !w_bad) ? w_onehot : '0;
  assign pe_if.GBWEI_data         = w_empty ? '0 : w_head[EW-1:TAG_W];
  assign pe_if.GBWEI_pe_idx       = w_empty ? '0 : w_head_tag.pe;
  assign pe_if.GBWEI_data_type    = w_empty ? '0 : w_head_tag.dtype;
  assign Wei_credit_ok = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < LP_DEPTH;
  assign dispatch_err  = r_err;

  wei_disp_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (SRAM_config_start),
    .i_push  (w_push),
    .i_dat   ({WeiData_rdata, r_tag}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Decode the head PEB into the one-hot valid pattern
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_PEB; i++) begin
      w_onehot[i] = (w_head_tag.peb == PEB_IDX_W'(i));
    end
  end

  // Capture the tags on read_en; the matching rdata arrives one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else if (SRAM_config_start) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= WeiData_read_en;
      if (WeiData_read_en) r_tag <= '{peb: Which_PEB_to_PE, pe: Which_PE_to_PE, dtype: data_type};
    end
  end

  // Sticky error: dropped word or discarded bad-index head; flush clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_err <= 1'b0;
    else if (SRAM_config_start)      r_err <= 1'b0;
    else if (w_ovf || (w_pop && w_bad)) r_err <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and drain-complete pulse; flush overrides everything
  always_comb begin
    w_state_nxt   = r_state;
    dispatch_done = 1'b0;
    if (SRAM_config_start) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (WeiData_read_en) w_state_nxt = RUN;
        RUN:     if (read_SRAM_done)  w_state_nxt = DRAIN;
        DRAIN: begin
          if (w_empty && !r_inflight) begin
            w_state_nxt   = IDLE;
            dispatch_done = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule
